stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer; successor to the fixed 4:1 single-bit mux2-tree mux.
- Adds per-channel valid/ready handshakes, round-robin or fixed-select arbitration and packet locking on in_last.
- Adds a one-entry registered output stage.
- Sits between multiple producers and a single downstream consumer.

Parameters:
N, 4, number of input channels (N >= 2)
W, 8, data width per channel
CW, $clog2(N), channel index width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mode  in  1  0 = round-robin, 1 = fixed select
sel  in  CW  channel index used when mode = 1
in_valid  in  N  per-channel valid
in_data  in  N*W  channel i occupies bits [i*W +: W]
in_last  in  N  per-channel end-of-packet marker
in_ready  out  N  per-channel ready; at most one bit set
out_valid  out  1  output entry holds data
out_data  out  W  registered data
out_last  out  1  registered last marker
out_ch  out  CW  source channel of current output entry
out_ready  in  1  downstream accepts

Behaviour:
- Reset (async, any time, including mid-packet):
  - out_valid = 0, out_data = 0, out_last = 0, out_ch = 0.
  - RR pointer = 0, state = IDLE, locked channel = 0.
  - No transfer in the reset cycle.
- Output slot:
  - load_ok = !out_valid || out_ready.
  - Transfer on channel g = in_valid[g] && in_ready[g].
  - in_ready[i] = load_ok && grant[i]; combinational, no dependency on in_valid of other channels beyond the arbitration below.
- Latency: a transfer in cycle t gives out_valid = 1 with that data/last/ch in cycle t+1.
- Output hold: while out_valid && !out_ready, out_data/out_last/out_ch stay stable.
- Back-to-back: full throughput (one beat/cycle) when out_ready is held high.
- States:
  - IDLE: no packet in progress.
  - LOCKED: a packet is in progress; grant fixed to lock_ch.
- Grant in IDLE, mode = 0:
  - Scan channels ptr, ptr+1, ..., wrapping mod N; grant the first with in_valid = 1.
  - No valid channel -> no grant.
- Grant in IDLE, mode = 1: grant = sel only if in_valid[sel]; no other channel is granted.
- Grant in LOCKED: grant = lock_ch only, regardless of mode/sel.
- Transitions on a transfer from channel g:
  - IDLE, in_last[g] = 0 -> LOCKED, lock_ch <= g.
  - IDLE, in_last[g] = 1 -> stay IDLE (single-beat packet).
  - LOCKED, in_last[g] = 1 -> IDLE.
  - LOCKED, in_last[g] = 0 -> stay LOCKED.
- Pointer: on a transfer completing a packet (in_last = 1) in mode 0, ptr <= (g+1) mod N.
  - Wrap is required for non-power-of-2 N (e.g. N = 3: ptr 2 -> 0).
  - Pointer unchanged in mode 1 and on non-last beats.
- Mode/sel changes: sampled only in IDLE; mid-packet changes have no effect until the packet ends.
- Simultaneous events:
  - Drain and load in the same cycle is allowed (load_ok = 1 when out_ready = 1); new entry replaces old.
  - Pointer update and state change happen together on the same edge.
- Out-of-range sel (sel >= N, non-power-of-2 N): no grant.

Decomposition:
- Package stream_mux_pkg holds:
  - state enum {IDLE, LOCKED}.
  - Helper function for next-index wrap mod N.
- Sub-module rr_arbiter, purely combinational:
  - Inputs: N-bit request, CW-bit pointer.
  - Outputs: one-hot grant, CW-bit index, any.
  - The top level applies the mode/lock overrides.

Test Plan:
1. Reset, then N=4 mode 0, all in_valid = 1, in_last = 1, out_ready = 1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuous from cycle 2.
2. Channel 1 sends a 3-beat packet (last on beat 3) while channels 0/2 stay valid -> three consecutive beats with out_ch = 1 and no interleave; next grant is channel 2.
3. out_ready = 0 for 5 cycles with channel 0 valid, data 0xA5 -> out_data holds 0xA5, in_ready = 0 throughout; one transfer when out_ready returns to 1.
4. mode = 1, sel = 2, channels 0..3 valid -> only channel 2 granted; changing sel to 3 mid-packet is ignored until out_last = 1, then channel 3 is granted.
5. N = 3, all valid single-beat traffic -> ptr wraps 2 -> 0, out_ch = 0,1,2,0; sel = 3 in mode 1 -> no grant.
6. Assert rst while LOCKED with out_valid = 1 -> out_valid = 0 immediately (async); after release, channel 0 is granted first and the state is IDLE.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Next channel index, wrapping to 0 after n-1 (works for any n, not only powers of two).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping mod N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    output logic [N-1:0]  grant_c_o,
    output logic [CW-1:0] idx_c_o,
    output logic          any_c_o
);

    always_comb begin
        int unsigned c;
        logic        found;
        grant_c_o = '0;
        idx_c_o   = '0;
        found     = 1'b0;
        c         = 32'(ptr_i);
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req_i[CW'(c)]) begin
                found                = 1'b1;
                grant_c_o[CW'(c)]    = 1'b1;
                idx_c_o              = CW'(c);
            end
            c = wrap_inc(c, N);
        end
        any_c_o = found;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with round-robin/fixed arbitration, packet locking and a registered output slot.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 8,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [CW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [CW-1:0]   out_ch,
    input  logic            out_ready
);

    state_e        state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] lock_ch_q, lock_ch_d;
    logic          lock_mode_q, lock_mode_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] out_ch_q, out_ch_d;

    logic [N-1:0]  arb_grant_c;
    logic [CW-1:0] arb_idx_c;
    logic          arb_any_c;

    logic [N-1:0]  grant_c;
    logic [CW-1:0] gidx_c;
    logic          load_ok_c;
    logic          xfer_c;
    logic          xfer_last_c;
    logic [W-1:0]  xfer_data_c;
    logic          eff_mode_c;

    rr_arbiter #(.N(N)) u_arb (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .grant_c_o (arb_grant_c),
        .idx_c_o   (arb_idx_c),
        .any_c_o   (arb_any_c)
    );

    // Grant selection: a locked packet overrides mode/sel; fixed mode ignores the pointer.
    always_comb begin
        grant_c = '0;
        gidx_c  = '0;
        if (state_q == LOCKED) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (CW'(i) == lock_ch_q) begin
                    grant_c[i] = 1'b1;
                end
            end
            gidx_c = lock_ch_q;
        end else if (mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (CW'(i) == sel && in_valid[i]) begin
                    grant_c[i] = 1'b1;
                    gidx_c     = sel;
                end
            end
        end else if (arb_any_c) begin
            grant_c = arb_grant_c;
            gidx_c  = arb_idx_c;
        end
    end

    always_comb begin
        load_ok_c   = !out_valid_q || out_ready;
        in_ready    = (load_ok_c && !rst) ? grant_c : '0;
        xfer_c      = |(in_valid & in_ready);
        xfer_last_c = |(in_last & grant_c);
        eff_mode_c  = (state_q == IDLE) ? mode : lock_mode_q;
        xfer_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_c[i]) begin
                xfer_data_c = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_ch_d   = lock_ch_q;
        lock_mode_d = lock_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;

        if (load_ok_c) begin
            out_valid_d = xfer_c;
            if (xfer_c) begin
                out_data_d = xfer_data_c;
                out_last_d = xfer_last_c;
                out_ch_d   = gidx_c;
            end
        end

        // The pointer only advances when a round-robin packet completes.
        if (xfer_c) begin
            if (xfer_last_c) begin
                state_d = IDLE;
                if (!eff_mode_c) begin
                    ptr_d = CW'(wrap_inc(32'(gidx_c), N));
                end
            end else if (state_q == IDLE) begin
                state_d     = LOCKED;
                lock_ch_d   = gidx_c;
                lock_mode_d = mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_ch_q   <= '0;
            lock_mode_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_ch_q   <= lock_ch_d;
            lock_mode_q <= lock_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance share stimulus and are checked against a packet-level model.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_valid = 4'd0;
    logic [3:0]  in_last = 4'd0;
    logic [31:0] in_data = 32'd0;

    logic [3:0]  rdy4;
    logic        ov4, ol4;
    logic [7:0]  od4;
    logic [1:0]  och4;
    logic [2:0]  rdy3;
    logic        ov3, ol3;
    logic [7:0]  od3;
    logic [1:0]  och3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy4), .out_valid(ov4), .out_data(od4), .out_last(ol4),
        .out_ch(och4), .out_ready(out_ready)
    );

    stream_mux_rr #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid[2:0]), .in_data(in_data[23:0]), .in_last(in_last[2:0]),
        .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_last(ol3),
        .out_ch(och3), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input int n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (N=%0d) actual=%0d required=%0d at %0t", nm, n, act, exp, $time);
        end
    endtask

    // Packet-level model: one entry per instance (0 -> N=4, 1 -> N=3).
    int m_busy[2]  = '{0, 0};
    int m_lock[2]  = '{0, 0};
    int m_lmode[2] = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_ov[2]    = '{0, 0};
    int m_od[2]    = '{0, 0};
    int m_ol[2]    = '{0, 0};
    int m_och[2]   = '{0, 0};

    function automatic int nch(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    function automatic int mgrant(input int u);
        if (m_busy[u] != 0) return m_lock[u];
        if (mode) begin
            if (int'(sel) < nch(u) && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < nch(u); k++) begin
            int c;
            c = (m_ptr[u] + k) % nch(u);
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_busy[u] <= 0; m_lock[u] <= 0; m_lmode[u] <= 0; m_ptr[u] <= 0;
                m_ov[u] <= 0; m_od[u] <= 0; m_ol[u] <= 0; m_och[u] <= 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                int g, em;
                bit lok, xf;
                g   = mgrant(u);
                lok = (m_ov[u] == 0) || out_ready;
                xf  = (g >= 0) && lok && in_valid[g];
                if (lok) m_ov[u] <= int'(xf);
                if (xf) begin
                    m_od[u]  <= int'(in_data[g*8 +: 8]);
                    m_ol[u]  <= int'(in_last[g]);
                    m_och[u] <= g;
                    em = (m_busy[u] != 0) ? m_lmode[u] : int'(mode);
                    if (in_last[g]) begin
                        m_busy[u] <= 0;
                        if (em == 0) m_ptr[u] <= (g + 1) % nch(u);
                    end else if (m_busy[u] == 0) begin
                        m_busy[u]  <= 1;
                        m_lock[u]  <= g;
                        m_lmode[u] <= int'(mode);
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int g;
            bit lok;
            logic [3:0] er, ar;
            g   = rst ? -1 : mgrant(u);
            lok = (m_ov[u] == 0) || out_ready;
            er  = 4'd0;
            if (g >= 0 && lok) er[g] = 1'b1;
            ar  = (u == 0) ? rdy4 : {1'b0, rdy3};
            chk("model_in_ready", nch(u), int'(ar), int'(er));
            chk("model_out_valid", nch(u), (u == 0) ? int'(ov4) : int'(ov3), m_ov[u]);
            if (m_ov[u] != 0) begin
                chk("model_out_data", nch(u), (u == 0) ? int'(od4) : int'(od3), m_od[u]);
                chk("model_out_last", nch(u), (u == 0) ? int'(ol4) : int'(ol3), m_ol[u]);
                chk("model_out_ch", nch(u), (u == 0) ? int'(och4) : int'(och3), m_och[u]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) cyc();
        chk("reset_out_valid", 4, int'(ov4), 0);
        chk("reset_out_data", 4, int'(od4), 0);
        chk("reset_out_last", 4, int'(ol4), 0);
        chk("reset_out_ch", 4, int'(och4), 0);
        chk("reset_out_valid", 3, int'(ov3), 0);
        rst = 1'b0;

        // Round-robin, single-beat packets on every channel
        mode = 1'b0; out_ready = 1'b1;
        in_valid = 4'hF; in_last = 4'hF;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_out_valid", 4, int'(ov4), 1);
            chk("rr_out_ch", 4, int'(och4), k % 4);
            chk("rr_out_data", 4, int'(od4), 16 + (k % 4));
            chk("rr_wrap_out_ch", 3, int'(och3), k % 3);
        end

        // Channel 1 three-beat packet, channels 0/2 also requesting
        in_valid = 4'b0111; in_last = 4'b1101; in_data[15:8] = 8'h21;
        cyc();
        chk("lock_beat1_ch", 4, int'(och4), 1);
        chk("lock_beat1_data", 4, int'(od4), 8'h21);
        chk("lock_beat1_last", 4, int'(ol4), 0);
        in_data[15:8] = 8'h22;
        cyc();
        chk("lock_beat2_ch", 4, int'(och4), 1);
        chk("lock_beat2_data", 4, int'(od4), 8'h22);
        in_data[15:8] = 8'h23; in_last[1] = 1'b1;
        cyc();
        chk("lock_beat3_ch", 4, int'(och4), 1);
        chk("lock_beat3_last", 4, int'(ol4), 1);
        cyc();
        chk("after_lock_ch", 4, int'(och4), 2);

        // Backpressure hold
        in_valid = 4'b0001; in_last = 4'hF; in_data[7:0] = 8'hA5;
        cyc();
        chk("bp_load_data", 4, int'(od4), 8'hA5);
        out_ready = 1'b0; in_data[7:0] = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold_data", 4, int'(od4), 8'hA5);
            chk("bp_hold_valid", 4, int'(ov4), 1);
            chk("bp_in_ready", 4, int'(rdy4), 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 4, int'(rdy4), 1);
        cyc();
        chk("bp_release_data", 4, int'(od4), 8'h5A);
        in_valid = 4'd0;
        cyc();
        chk("bp_drained_valid", 4, int'(ov4), 0);

        // Fixed select with mid-packet sel change
        mode = 1'b1; sel = 2'd2;
        in_valid = 4'hF; in_last = 4'b1011;
        in_data = {8'h43, 8'h42, 8'h41, 8'h40};
        #1 chk("fixed_in_ready", 4, int'(rdy4), 4'b0100);
        cyc();
        chk("fixed_beat1_ch", 4, int'(och4), 2);
        sel = 2'd3;
        #1 chk("fixed_sel_ignored", 4, int'(rdy4), 4'b0100);
        cyc();
        chk("fixed_beat2_ch", 4, int'(och4), 2);
        in_last[2] = 1'b1;
        cyc();
        chk("fixed_beat3_ch", 4, int'(och4), 2);
        chk("fixed_beat3_last", 4, int'(ol4), 1);
        #1 chk("fixed_new_sel_ready", 4, int'(rdy4), 4'b1000);
        cyc();
        chk("fixed_new_sel_ch", 4, int'(och4), 3);
        chk("fixed_new_sel_data", 4, int'(od4), 8'h43);
        chk("sel_out_of_range_ready", 3, int'(rdy3), 0);
        chk("sel_out_of_range_valid", 3, int'(ov3), 0);

        // Asynchronous reset in the middle of a packet
        mode = 1'b0; in_valid = 4'b0001; in_last = 4'd0; in_data[7:0] = 8'h60;
        cyc();
        chk("pre_rst_valid", 4, int'(ov4), 1);
        chk("pre_rst_ch", 4, int'(och4), 0);
        #1 rst = 1'b1;
        #1 chk("async_rst_valid", 4, int'(ov4), 0);
        chk("async_rst_valid", 3, int'(ov3), 0);
        cyc();
        rst = 1'b0;
        in_valid = 4'hF; in_last = 4'hF;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        cyc();
        chk("post_rst_first_ch", 4, int'(och4), 0);
        chk("post_rst_first_data", 4, int'(od4), 8'h10);
        cyc();
        chk("post_rst_idle_next_ch", 4, int'(och4), 1);

        in_valid = 4'd0;
        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
